// File: rtl/cfg_reg_pkg.sv
// Shared defaults for the configuration register bank: geometry and power-on contents.
package cfg_reg_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

    // Register i occupies bits [i*8 +: 8]: reg3 = 8'h20, reg2 = 8'h81, all others zero.
    localparam logic [DEF_DEPTH*DEF_DATA_W-1:0] DEF_RST_VAL =
        {96'h0, 8'h20, 8'h81, 16'h0};

endpackage

// File: rtl/cfg_reg_rd_port.sv
// One registered read port (latency 1); data holds while no read is requested.
module cfg_reg_rd_port
    import cfg_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 RdEn,
    input  logic [ADDR_W-1:0]                    RdAddr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]     mem_cur,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]     mem_nxt,
    output logic [DATA_W-1:0]                    RdData,
    output logic                                 RdValid
);

    logic [DATA_W-1:0] rd_word;

    // Write-first returns the value storage is about to take this edge.
    assign rd_word = (BYPASS != 0) ? mem_nxt[RdAddr] : mem_cur[RdAddr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            RdData  <= '0;
            RdValid <= 1'b0;
        end else begin
            RdValid <= RdEn;
            if (RdEn) begin
                RdData <= rd_word;
            end
        end
    end

endmodule

// File: rtl/cfg_reg_bank.sv
// Flop-based configuration register bank with masked bus writes, hardware status
// writes, two independent read ports and a continuous export of the low registers.
module cfg_reg_bank
    import cfg_reg_pkg::*;
#(
    parameter int                                   DATA_W  = DEF_DATA_W,
    parameter int                                   ADDR_W  = DEF_ADDR_W,
    parameter int                                   NUM_EXP = 4,
    parameter logic [2**ADDR_W-1:0]                 RO_MASK = '0,
    parameter logic [(2**ADDR_W)*DATA_W-1:0]        RST_VAL = DEF_RST_VAL,
    parameter int                                   BYPASS  = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        WrEn,
    input  logic [ADDR_W-1:0]           WrAddr,
    input  logic [DATA_W-1:0]           WrData,
    input  logic [DATA_W-1:0]           WrMask,
    input  logic                        HwWrEn,
    input  logic [ADDR_W-1:0]           HwAddr,
    input  logic [DATA_W-1:0]           HwData,
    input  logic                        RdEn_A,
    input  logic [ADDR_W-1:0]           RdAddr_A,
    output logic [DATA_W-1:0]           RdData_A,
    output logic                        RdValid_A,
    input  logic                        RdEn_B,
    input  logic [ADDR_W-1:0]           RdAddr_B,
    output logic [DATA_W-1:0]           RdData_B,
    output logic                        RdValid_B,
    output logic                        WrErr,
    output logic [NUM_EXP*DATA_W-1:0]   REG_EXP
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_nxt;
    logic                         addr_clash;
    logic                         bus_wr_ok;
    logic                         bus_wr_rej;

    // A hardware write to the same address silently wins; the bus write is not an error.
    assign addr_clash = HwWrEn && (HwAddr == WrAddr);
    assign bus_wr_ok  = WrEn && !addr_clash && !RO_MASK[WrAddr];
    assign bus_wr_rej = WrEn && !addr_clash &&  RO_MASK[WrAddr];

    always_comb begin
        mem_nxt = mem_q;
        if (bus_wr_ok) begin
            mem_nxt[WrAddr] = (mem_q[WrAddr] & ~WrMask) | (WrData & WrMask);
        end
        if (HwWrEn) begin
            mem_nxt[HwAddr] = HwData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q <= RST_VAL;
            WrErr <= 1'b0;
        end else begin
            mem_q <= mem_nxt;
            WrErr <= bus_wr_rej;
        end
    end

    assign REG_EXP = mem_q[NUM_EXP-1:0];

    cfg_reg_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_a (
        .CLK     (CLK),
        .RST     (RST),
        .RdEn    (RdEn_A),
        .RdAddr  (RdAddr_A),
        .mem_cur (mem_q),
        .mem_nxt (mem_nxt),
        .RdData  (RdData_A),
        .RdValid (RdValid_A)
    );

    cfg_reg_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_b (
        .CLK     (CLK),
        .RST     (RST),
        .RdEn    (RdEn_B),
        .RdAddr  (RdAddr_B),
        .mem_cur (mem_q),
        .mem_nxt (mem_nxt),
        .RdData  (RdData_B),
        .RdValid (RdValid_B)
    );

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Bench for cfg_reg_bank: a write-first and a read-old instance share stimulus and
// are checked against an array-based model of the register file.
module tb_cfg_reg_bank;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WrEn;
    logic [3:0]  WrAddr;
    logic [7:0]  WrData;
    logic [7:0]  WrMask;
    logic        HwWrEn;
    logic [3:0]  HwAddr;
    logic [7:0]  HwData;
    logic        RdEn_A;
    logic [3:0]  RdAddr_A;
    logic        RdEn_B;
    logic [3:0]  RdAddr_B;

    logic [7:0]   rd_a1, rd_b1, rd_a0, rd_b0;
    logic         va1, vb1, va0, vb0, err1, err0;
    logic [127:0] exp1;
    logic [31:0]  exp0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] mdl [16];
    logic [7:0] e_a1, e_b1, e_a0, e_b0;
    logic       e_va, e_vb, e_err;
    logic [15:0] ro = 16'h0002;

    always #5 CLK = ~CLK;

    cfg_reg_bank #(.NUM_EXP(16), .RO_MASK(16'h0002), .BYPASS(1)) dut_b1 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrMask(WrMask), .HwWrEn(HwWrEn), .HwAddr(HwAddr), .HwData(HwData),
        .RdEn_A(RdEn_A), .RdAddr_A(RdAddr_A), .RdData_A(rd_a1), .RdValid_A(va1),
        .RdEn_B(RdEn_B), .RdAddr_B(RdAddr_B), .RdData_B(rd_b1), .RdValid_B(vb1),
        .WrErr(err1), .REG_EXP(exp1)
    );

    cfg_reg_bank #(.RO_MASK(16'h0002), .BYPASS(0)) dut_b0 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrMask(WrMask), .HwWrEn(HwWrEn), .HwAddr(HwAddr), .HwData(HwData),
        .RdEn_A(RdEn_A), .RdAddr_A(RdAddr_A), .RdData_A(rd_a0), .RdValid_A(va0),
        .RdEn_B(RdEn_B), .RdAddr_B(RdAddr_B), .RdData_B(rd_b0), .RdValid_B(vb0),
        .WrErr(err0), .REG_EXP(exp0)
    );

    function automatic logic [7:0] rst_val(int i);
        return (i == 2) ? 8'h81 : (i == 3) ? 8'h20 : 8'h00;
    endfunction

    task automatic idle();
        RST = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0; WrMask = '0;
        HwWrEn = 1'b0; HwAddr = '0; HwData = '0;
        RdEn_A = 1'b0; RdAddr_A = '0; RdEn_B = 1'b0; RdAddr_B = '0;
    endtask

    // Advance one clock: derive expected results from the current inputs, then
    // sample 1 ns after the edge.
    task automatic tick();
        logic [7:0] pre [16];
        logic [7:0] post [16];
        logic       drop;
        pre  = mdl;
        post = mdl;
        if (RST) begin
            for (int i = 0; i < 16; i++) post[i] = rst_val(i);
            e_a1 = 0; e_b1 = 0; e_a0 = 0; e_b0 = 0;
            e_va = 0; e_vb = 0; e_err = 0;
        end else begin
            drop = WrEn && HwWrEn && (WrAddr == HwAddr);
            if (WrEn && !drop && !ro[WrAddr])
                post[WrAddr] = (pre[WrAddr] & ~WrMask) | (WrData & WrMask);
            if (HwWrEn) post[HwAddr] = HwData;
            e_err = WrEn && !drop && ro[WrAddr];
            e_va  = RdEn_A;
            e_vb  = RdEn_B;
            if (RdEn_A) begin e_a1 = post[RdAddr_A]; e_a0 = pre[RdAddr_A]; end
            if (RdEn_B) begin e_b1 = post[RdAddr_B]; e_b0 = pre[RdAddr_B]; end
        end
        @(posedge CLK);
        mdl = post;
        #1;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (exp1[i*8 +: 8] !== rst_val(i)) begin
                n_err++;
                $display("FAIL reset_reg%0d got %h want %h", i, exp1[i*8 +: 8], rst_val(i));
            end
        end
        n_cmp++;
        if (exp0 !== 32'h2081_0000) begin
            n_err++; $display("FAIL reset_exp0 got %h want 20810000", exp0);
        end
        n_cmp++;
        if ({va1, vb1, va0, vb0, err1, err0} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 000000", {va1, vb1, va0, vb0, err1, err0});
        end
        n_cmp++;
        if ({rd_a1, rd_b1, rd_a0, rd_b0} !== 32'h0) begin
            n_err++; $display("FAIL reset_rddata got %h want 0", {rd_a1, rd_b1, rd_a0, rd_b0});
        end
    endtask

    task automatic test_masked_write();
        idle(); HwWrEn = 1; HwAddr = 5; HwData = 8'hF0; tick();
        idle(); WrEn = 1; WrAddr = 5; WrData = 8'h0F; WrMask = 8'h3C; tick();
        idle();
        n_cmp++;
        if (exp1[5*8 +: 8] !== 8'hCC) begin
            n_err++; $display("FAIL masked_reg5 got %h want cc", exp1[5*8 +: 8]);
        end
        RdEn_A = 1; RdAddr_A = 5; tick(); idle();
        n_cmp++;
        if (rd_a1 !== 8'hCC || va1 !== 1'b1) begin
            n_err++; $display("FAIL masked_read got %h/%b want cc/1", rd_a1, va1);
        end
    endtask

    task automatic test_ro_reject();
        idle(); WrEn = 1; WrAddr = 1; WrData = 8'hAA; WrMask = 8'hFF; tick(); idle();
        n_cmp++;
        if (exp1[15:8] !== 8'h00 || exp0[15:8] !== 8'h00) begin
            n_err++; $display("FAIL ro_unchanged got %h/%h want 00", exp1[15:8], exp0[15:8]);
        end
        n_cmp++;
        if (err1 !== 1'b1 || err0 !== 1'b1) begin
            n_err++; $display("FAIL ro_wrerr_pulse got %b%b want 11", err1, err0);
        end
        tick();
        n_cmp++;
        if (err1 !== 1'b0) begin
            n_err++; $display("FAIL ro_wrerr_clear got %b want 0", err1);
        end
        HwWrEn = 1; HwAddr = 1; HwData = 8'h55; tick(); idle();
        n_cmp++;
        if (exp1[15:8] !== 8'h55 || err1 !== 1'b0) begin
            n_err++; $display("FAIL ro_hw_write got %h/%b want 55/0", exp1[15:8], err1);
        end
    endtask

    task automatic test_collision();
        idle();
        WrEn = 1; WrAddr = 6; WrData = 8'h11; WrMask = 8'hFF;
        HwWrEn = 1; HwAddr = 6; HwData = 8'h22;
        tick(); idle();
        n_cmp++;
        if (exp1[6*8 +: 8] !== 8'h22 || err1 !== 1'b0) begin
            n_err++; $display("FAIL collision got %h/%b want 22/0", exp1[6*8 +: 8], err1);
        end
        // RO address colliding with a hardware write is also not an error.
        WrEn = 1; WrAddr = 1; WrData = 8'h99; WrMask = 8'hFF;
        HwWrEn = 1; HwAddr = 1; HwData = 8'h3C;
        tick(); idle();
        n_cmp++;
        if (exp1[15:8] !== 8'h3C || err1 !== 1'b0) begin
            n_err++; $display("FAIL collision_ro got %h/%b want 3c/0", exp1[15:8], err1);
        end
    endtask

    task automatic test_bypass();
        idle(); HwWrEn = 1; HwAddr = 4; HwData = 8'h00; tick();
        idle(); WrEn = 1; WrAddr = 4; WrData = 8'h7E; WrMask = 8'hFF;
        RdEn_A = 1; RdAddr_A = 4; RdEn_B = 1; RdAddr_B = 4;
        tick(); idle();
        n_cmp++;
        if (rd_a1 !== 8'h7E) begin
            n_err++; $display("FAIL bypass_write_first got %h want 7e", rd_a1);
        end
        n_cmp++;
        if (rd_a0 !== 8'h00) begin
            n_err++; $display("FAIL bypass_read_old got %h want 00", rd_a0);
        end
        n_cmp++;
        if (rd_b1 !== rd_a1 || rd_b0 !== rd_a0) begin
            n_err++; $display("FAIL same_addr_ports got %h/%h %h/%h want equal", rd_a1, rd_b1, rd_a0, rd_b0);
        end
        tick();
        n_cmp++;
        if (va1 !== 1'b0 || rd_a1 !== 8'h7E || rd_a0 !== 8'h00) begin
            n_err++; $display("FAIL rd_hold got %b %h %h want 0 7e 00", va1, rd_a1, rd_a0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle();
            RST      = ($urandom_range(0, 49) == 0);
            WrEn     = $urandom_range(0, 1);
            WrAddr   = $urandom_range(0, 15);
            WrData   = $urandom;
            WrMask   = $urandom;
            HwWrEn   = ($urandom_range(0, 3) == 0);
            HwAddr   = ($urandom_range(0, 3) == 0) ? WrAddr : 4'($urandom_range(0, 15));
            HwData   = $urandom;
            RdEn_A   = $urandom_range(0, 1);
            RdAddr_A = ($urandom_range(0, 2) == 0) ? WrAddr : 4'($urandom_range(0, 15));
            RdEn_B   = $urandom_range(0, 1);
            RdAddr_B = ($urandom_range(0, 2) == 0) ? HwAddr : RdAddr_A;
            tick();
            n_cmp++;
            if (err1 !== e_err || err0 !== e_err) begin
                n_err++; $display("FAIL rnd_wrerr c%0d got %b%b want %b", c, err1, err0, e_err);
            end
            n_cmp++;
            if (va1 !== e_va || va0 !== e_va || vb1 !== e_vb || vb0 !== e_vb) begin
                n_err++; $display("FAIL rnd_valid c%0d got %b%b%b%b want %b%b", c, va1, va0, vb1, vb0, e_va, e_vb);
            end
            n_cmp++;
            if (rd_a1 !== e_a1 || rd_b1 !== e_b1) begin
                n_err++; $display("FAIL rnd_rd_bypass c%0d got %h/%h want %h/%h", c, rd_a1, rd_b1, e_a1, e_b1);
            end
            n_cmp++;
            if (rd_a0 !== e_a0 || rd_b0 !== e_b0) begin
                n_err++; $display("FAIL rnd_rd_old c%0d got %h/%h want %h/%h", c, rd_a0, rd_b0, e_a0, e_b0);
            end
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (exp1[i*8 +: 8] !== mdl[i] || (i < 4 && exp0[i*8 +: 8] !== mdl[i])) begin
                    n_err++; $display("FAIL rnd_reg%0d c%0d got %h want %h", i, c, exp1[i*8 +: 8], mdl[i]);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle(); RdEn_B = 1; RdAddr_B = 2; tick();
        RST = 1; WrEn = 1; WrAddr = 3; WrData = 8'hFF; WrMask = 8'hFF;
        HwWrEn = 1; HwAddr = 7; HwData = 8'h5A; RdEn_B = 1; RdAddr_B = 3;
        tick(); idle();
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (exp1[i*8 +: 8] !== rst_val(i)) begin
                n_err++; $display("FAIL rstmid_reg%0d got %h want %h", i, exp1[i*8 +: 8], rst_val(i));
            end
        end
        n_cmp++;
        if (vb1 !== 1'b0 || vb0 !== 1'b0 || rd_b1 !== 8'h00 || err1 !== 1'b0) begin
            n_err++; $display("FAIL rstmid_portb got %b%b %h %b want 00 00 0", vb1, vb0, rd_b1, err1);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        test_reset();
        test_masked_write();
        test_ro_reject();
        test_collision();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cfg_reg_bank.md
CFG_REG_BANK -- requirements
Module: cfg_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_EXP, default 4, number of registers exported (1..DEPTH).
REQ-004 SHALL have parameter RO_MASK, default all-zero, DEPTH bits; bit i=1 makes register i read-only to the bus port.
REQ-005 SHALL have parameter RST_VAL, default {reg3=8'h20, reg2=8'h81, others 0}, DEPTH*DATA_W bits, register i at slice i.
REQ-006 SHALL have parameter BYPASS, default 1; 1 = write-first on same-address read/write, 0 = read-old.
REQ-007 CLK  input  1  sole clock, rising edge.
REQ-008 RST  input  1  synchronous, active-high reset.
REQ-009 WrEn  input  1  bus write strobe.
REQ-010 WrAddr  input  ADDR_W  bus write address.
REQ-011 WrData  input  DATA_W  bus write data.
REQ-012 WrMask  input  DATA_W  per-bit write enable; 1 = bit updated.
REQ-013 HwWrEn / HwAddr / HwData  input  1 / ADDR_W / DATA_W  hardware status-update port, ignores RO_MASK.
REQ-014 RdEn_A / RdAddr_A  input  1 / ADDR_W  read port A request.
REQ-015 RdData_A / RdValid_A  output  DATA_W / 1  read port A result.
REQ-016 RdEn_B / RdAddr_B / RdData_B / RdValid_B  same as port A, independent port B.
REQ-017 WrErr  output  1  one-cycle pulse on rejected bus write.
REQ-018 REG_EXP  output  NUM_EXP*DATA_W  registers 0..NUM_EXP-1 flattened, register i at slice i, continuous.

Function
REQ-019 Bus write SHALL, one edge after WrEn=1, set reg[WrAddr] = (old & ~WrMask) | (WrData & WrMask), when RO_MASK[WrAddr]=0.
REQ-020 Bus write to RO address SHALL leave storage unchanged and pulse WrErr=1 for exactly the following cycle.
REQ-021 Hardware write SHALL set reg[HwAddr]=HwData (full width) one edge after HwWrEn=1.
REQ-022 Same-cycle bus and hardware write to same address SHALL apply hardware write only; bus write dropped, WrErr not pulsed.
REQ-023 Same-cycle bus and hardware writes to different addresses SHALL both apply.
REQ-024 Each read port SHALL register RdData = reg[RdAddr] and RdValid=1 one cycle after RdEn=1 (latency 1); RdValid=0 the cycle after RdEn=0.
REQ-025 RdData SHALL hold its last value while RdValid=0.
REQ-026 Reads SHALL be legal concurrently with writes (no RdEn/WrEn mutual exclusion).
REQ-027 Same-cycle read and write to same address: BYPASS=1 SHALL return the post-write value (hardware write taking precedence per REQ-022); BYPASS=0 SHALL return the pre-write value.
REQ-028 Both ports reading same address in same cycle SHALL return identical data.
REQ-029 REG_EXP SHALL reflect storage updates in the same cycle storage changes (no extra latency).

Reset
REQ-030 RST=1 at a rising edge SHALL load reg[i]=RST_VAL slice i for all i.
REQ-031 RST SHALL clear RdData_A/B to 0, RdValid_A/B to 0, WrErr to 0.
REQ-032 RST SHALL override any concurrent write or read; requests in that cycle are discarded.

Structure
REQ-033 Shared package cfg_reg_pkg SHALL hold default DATA_W, ADDR_W and the default RST_VAL constant.
REQ-034 Read port logic SHALL be one sub-module cfg_reg_rd_port, instantiated twice (A, B).
REQ-035 Storage SHALL be flops (no memory macro), to allow full-width reset and continuous export.

Verification
REQ-036 Reset: assert RST 1 cycle -> reg2=8'h81, reg3=8'h20, others 0, RdValid_A/B=0, WrErr=0.
REQ-037 Masked write: reg5=8'hF0, WrData=8'h0F, WrMask=8'h3C -> reg5=8'hCC; read A next cycle RdData_A=8'hCC, RdValid_A=1.
REQ-038 RO reject: RO_MASK bit 1 set, bus write 8'hAA to addr 1 -> reg1 unchanged, WrErr pulses 1 cycle; HwWrEn 8'h55 to addr 1 -> reg1=8'h55.
REQ-039 Collision: same cycle bus write 8'h11 and hw write 8'h22 to addr 6 -> reg6=8'h22, WrErr=0.
REQ-040 Bypass: BYPASS=1, reg4=8'h00, write 8'h7E and read A addr 4 same cycle -> RdData_A=8'h7E; BYPASS=0 -> 8'h00.
REQ-041 Reset mid-operation: RST with WrEn and RdEn_B active -> storage equals RST_VAL, RdValid_B=0 next cycle.
